// File: rtl/mux_rr_sched_pkg.sv
// mux_rr_sched_pkg: shared constants and FSM state encoding for the round-robin mux scheduler
package mux_rr_sched_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux_rr_sched_rr_pick4.sv
// rr_pick4: combinational round-robin picker; first requester at or after start (wrapping) wins
//   req   - request vector
//   start - highest-priority index for this search
//   found - any request present
//   idx   - winning index
module rr_pick4
  import mux_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] ofs;
  always_comb begin
    rot   = {req[start + 2'd3], req[start + 2'd2], req[start + 2'd1], req[start]};
    ofs   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    found = |req;
    idx   = start + ofs;
  end
endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner of a shared 4:1 bit mux with bounded hold and registered output capture
//   clk, rst_n - clock, synchronous active-low reset
//   req        - request vector, req[i] asks to route W[i]
//   f          - mux output fed back
//   gnt        - one-hot grant, zero when idle
//   s1, s0     - mux select driven to the owner's index
//   busy       - a grant is active
//   f_q, f_vld - f captured under a grant, valid the cycle after capture
module mux_rr_sched
  import mux_rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             f,
  output logic [N_REQ-1:0] gnt,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic             f_q,
  output logic             f_vld
);
  state_t           state, state_nx;
  logic [SEL_W-1:0] owner, owner_nx, last, last_nx, start, idx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             found, rel;
  // owner+1 equals the post-release last+1, so one picker serves both idle entry and release
  assign start = (state == IDLE ? last : owner) + 2'd1;
  rr_pick4 u_pick (.req(req), .start(start), .found(found), .idx(idx));
  assign busy = state == GRANT;
  assign gnt  = busy ? N_REQ'(1) << owner : '0;
  // owner doubles as the select register and keeps its value while idle
  assign s1   = owner[1];
  assign s0   = owner[0];
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    rel      = busy && (!req[owner] || cnt == CNT_W'(MAX_HOLD));
    if (!busy) begin
      if (found) begin
        state_nx = GRANT;
        owner_nx = idx;
        cnt_nx   = CNT_W'(1);
      end
    end else if (rel) begin
      last_nx  = owner;
      state_nx = found ? GRANT : IDLE;
      owner_nx = found ? idx : owner;
      cnt_nx   = found ? CNT_W'(1) : '0;
    end else begin
      cnt_nx = cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= 2'd3;
      cnt   <= '0;
      f_q   <= 1'b0;
      f_vld <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      f_q   <= busy ? f : f_q;
      f_vld <= busy;
    end
  end
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: random and directed stimulus against a behavioural model, MAX_HOLD=4 and MAX_HOLD=1
module tb_mux_rr_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] w = '0;
  logic [3:0] gnt [2];
  logic       s1 [2], s0 [2], busy [2], f_q [2], f_vld [2], f [2];
  int errors = 0, checks = 0;
  int m_busy [2], m_owner [2], m_last [2], m_cnt [2], m_fq [2], m_fvld [2];
  int mh [2] = '{4, 1};

  always #5 clk = ~clk;

  assign f[0] = w[{s1[0], s0[0]}];
  assign f[1] = w[{s1[1], s0[1]}];

  mux_rr_sched #(.MAX_HOLD(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .f(f[0]), .gnt(gnt[0]), .s1(s1[0]), .s0(s0[0]),
    .busy(busy[0]), .f_q(f_q[0]), .f_vld(f_vld[0]));
  mux_rr_sched #(.MAX_HOLD(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .f(f[1]), .gnt(gnt[1]), .s1(s1[1]), .s0(s0[1]),
    .busy(busy[1]), .f_q(f_q[1]), .f_vld(f_vld[1]));

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  function automatic int search(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model(input int d);
    int win;
    if (!rst_n) begin
      m_busy[d] = 0; m_owner[d] = 0; m_last[d] = 3; m_cnt[d] = 0; m_fq[d] = 0; m_fvld[d] = 0;
      return;
    end
    if (m_busy[d] != 0) m_fq[d] = int'(w[m_owner[d]]);
    m_fvld[d] = m_busy[d];
    if (m_busy[d] == 0) begin
      win = search(m_last[d], req);
      if (win >= 0) begin m_busy[d] = 1; m_owner[d] = win; m_cnt[d] = 1; end
    end else if (!req[m_owner[d]] || m_cnt[d] == mh[d]) begin
      m_last[d] = m_owner[d];
      win = search(m_owner[d], req);
      if (win >= 0) begin m_owner[d] = win; m_cnt[d] = 1; end
      else m_busy[d] = 0;
    end else begin
      m_cnt[d]++;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model(0);
      model(1);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("gnt%0d", d), gnt[d], m_busy[d] != 0 ? 4'(1 << m_owner[d]) : 4'b0000);
        chk($sformatf("sel%0d", d), 4'({s1[d], s0[d]}), 4'(m_owner[d]));
        chk($sformatf("busy%0d", d), 4'(busy[d]), 4'(m_busy[d]));
        chk($sformatf("f_q%0d", d), 4'(f_q[d]), 4'(m_fq[d]));
        chk($sformatf("f_vld%0d", d), 4'(f_vld[d]), 4'(m_fvld[d]));
      end
    end
  endtask

  initial begin
    step(2);
    rst_n = 1'b1;
    step(5);
    w = 4'b0101; req = 4'b0001;
    step(10);
    req = 4'b0000;
    step(2);
    req = 4'b1111;
    step(18);
    req = 4'b0000;
    step(2);
    w = 4'b1101; req = 4'b0100;
    step(2);
    req = 4'b1011;
    step(3);
    req = 4'b0000;
    step(2);
    req = 4'b0010;
    step(4);
    req = 4'b0000;
    step(3);
    req = 4'b1000;
    step(3);
    rst_n = 1'b0; req = 4'b1001;
    step(1);
    rst_n = 1'b1;
    step(3);
    for (int i = 0; i < 500; i++) begin
      req   = 4'($urandom);
      w     = 4'($urandom);
      rst_n = $urandom_range(0, 49) != 0;
      step($urandom_range(1, 4));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
